// File: rtl/prog_fetch_pkg.sv
// Shared types and helpers for the two-half-word instruction fetch stage.
// Holds the FSM encoding and the half-word address mapping.
package prog_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int HALF_W  = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LO    = 2'd1,
        S_HI    = 2'd2,
        S_VALID = 2'd3
    } state_e;

    // Bit 15 of the word address is dropped, so 0x8000+n aliases n.
    function automatic logic [HALF_W-1:0] half_addr(
        input logic [HALF_W-1:0] pc,
        input logic              hi
    );
        return {pc[14:0], hi};
    endfunction

endpackage

// File: rtl/prog_fetch_lat_counter.sv
// Memory-latency counter: counts 0..MEM_LAT-1 while enabled.
// done flags the last cycle of a MEM_LAT-cycle memory access.
module lat_counter #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam logic [1:0] LAST = 2'(MEM_LAT - 1);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    assign done = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 2'd0;
        end else if (en) begin
            cnt_d = done ? 2'd0 : cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_fetch.sv
// Instruction fetch stage: builds a 32-bit instruction from two
// 16-bit program-memory reads and stalls the core while in flight.
module prog_fetch
    import prog_fetch_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [HALF_W-1:0]  pc_addr,
    input  logic               fetch_req,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic               cpu_stall,
    output logic [HALF_W-1:0]  mem_addr,
    output logic               mem_rd,
    input  logic [HALF_W-1:0]  mem_data
);

    if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
        $error("prog_fetch: MEM_LAT must be 1..4");
    end

    state_e              state_q, state_d;
    logic [HALF_W-1:0]   pc_q, pc_d;
    logic [HALF_W-1:0]   lo_q, lo_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                valid_q, valid_d;
    logic [HALF_W-1:0]   addr_q, addr_d;
    logic                rd_q, rd_d;
    logic                cnt_en;
    logic                lat_done;

    assign cnt_en = (state_q == S_LO) || (state_q == S_HI);

    lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat (
        .clk  (clk),
        .rst  (rst),
        .clr  (!cnt_en),
        .en   (cnt_en),
        .done (lat_done)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        lo_d    = lo_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        valid_d = 1'b0;
        rd_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                pc_d    = pc_addr;
                addr_d  = half_addr(pc_addr, 1'b0);
                rd_d    = 1'b1;
                state_d = S_LO;
            end
            S_LO: begin
                rd_d = 1'b1;
                if (lat_done) begin
                    lo_d    = mem_data;
                    addr_d  = half_addr(pc_q, 1'b1);
                    state_d = S_HI;
                end
            end
            S_HI: begin
                rd_d = 1'b1;
                if (lat_done) begin
                    instr_d = {mem_data, lo_q};
                    valid_d = 1'b1;
                    rd_d    = 1'b0;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                valid_d = 1'b1;
                if (fetch_req) begin
                    pc_d    = pc_addr;
                    addr_d  = half_addr(pc_addr, 1'b0);
                    rd_d    = 1'b1;
                    valid_d = 1'b0;
                    state_d = S_LO;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            lo_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            lo_q    <= lo_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign cpu_stall   = !valid_q;
    assign mem_addr    = addr_q;
    assign mem_rd      = rd_q;

endmodule
